// File: rtl/eth_phy_10g_link_ctrl.sv
// 10G PHY RX link bring-up/supervision FSM with optional PRBS31 test (ETH_PHY_10G_LINK_CTRL_PRBS_EN).
// All outputs registered (one cycle after the deciding input); no backpressure, inputs sampled every cycle.
module eth_phy_10g_link_ctrl #(
    parameter int RESET_CYCLES       = 64,
    parameter int LOCK_TIMEOUT       = 1000000,
    parameter int STABLE_CYCLES      = 19531,
    parameter int MAX_RETRIES        = 15,
    parameter int PRBS_TEST_CYCLES   = 156250,
    parameter int PRBS_SETTLE_CYCLES = 64,
    parameter int ERR_WIDTH          = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 rx_block_lock,
    input  logic                 rx_high_ber,
    input  logic [6:0]           rx_error_count,
    input  logic                 test_start,
    output logic                 serdes_rx_reset_req,
    output logic                 link_up,
    output logic                 link_fail,
    output logic [2:0]           link_state,
    output logic [3:0]           retry_count,
    output logic [15:0]          link_down_count,
    output logic                 cfg_rx_prbs31_enable,
    output logic                 cfg_tx_prbs31_enable,
    output logic                 test_busy,
    output logic                 test_done,
    output logic                 test_aborted,
    output logic [ERR_WIDTH-1:0] test_errors
);

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_RESET       = 3'd1,
        ST_WAIT_LOCK   = 3'd2,
        ST_WAIT_STABLE = 3'd3,
        ST_LINK_UP     = 3'd4,
        ST_PRBS        = 3'd5,
        ST_FAIL        = 3'd6
    } state_t;

    // One shared phase timer, sized for the longest phase.
    localparam int PRBS_TOTAL = PRBS_SETTLE_CYCLES + PRBS_TEST_CYCLES;
    localparam int MAX_A      = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_B      = (STABLE_CYCLES > PRBS_TOTAL) ? STABLE_CYCLES : PRBS_TOTAL;
    localparam int TMR_MAX    = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int TMR_W      = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] RST_LAST    = TMR_W'(RESET_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOCK_LAST   = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] STABLE_LAST = TMR_W'(STABLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] PRBS_LAST   = TMR_W'(PRBS_TOTAL - 1);
    localparam logic [3:0]       MAX_RETRY4  = 4'(MAX_RETRIES);

    state_t           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [3:0]       retry_q, retry_d;
    logic [15:0]      down_q, down_d;
    logic             req_q, req_d;
    logic             up_q, up_d;
    logic             fail_q, fail_d;
    logic             rx_good;
    logic             prbs_start;
    logic             test_end;
    logic             test_abort;

    assign rx_good = rx_block_lock & ~rx_high_ber;

`ifdef ETH_PHY_10G_LINK_CTRL_PRBS_EN
    assign prbs_start = test_start;
`else
    assign prbs_start = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        retry_d    = retry_q;
        down_d     = down_q;
        test_end   = 1'b0;
        test_abort = 1'b0;
        if (!enable) begin
            state_d    = ST_IDLE;
            tmr_d      = '0;
            retry_d    = '0;
            test_end   = (state_q == ST_PRBS);
            test_abort = (state_q == ST_PRBS);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_RESET;
                    tmr_d   = '0;
                end
                ST_RESET: begin
                    if (tmr_q == RST_LAST) begin
                        state_d = ST_WAIT_LOCK;
                        tmr_d   = '0;
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (rx_good) begin
                        state_d = ST_WAIT_STABLE;
                        tmr_d   = '0;
                    end else if (tmr_q == LOCK_LAST) begin
                        tmr_d   = '0;
                        retry_d = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;
                        if ((MAX_RETRIES != 0) && (retry_d == MAX_RETRY4)) begin
                            state_d = ST_FAIL;
                        end else begin
                            state_d = ST_RESET;
                        end
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end
                ST_WAIT_STABLE: begin
                    if (!rx_good) begin
                        state_d = ST_WAIT_LOCK;
                        tmr_d   = '0;
                    end else if (tmr_q == STABLE_LAST) begin
                        state_d = ST_LINK_UP;
                        tmr_d   = '0;
                        retry_d = '0;
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end
                ST_LINK_UP: begin
                    // Loss of lock outranks a coincident test request.
                    if (!rx_good) begin
                        state_d = ST_WAIT_LOCK;
                        tmr_d   = '0;
                        down_d  = (down_q == 16'hFFFF) ? down_q : down_q + 16'd1;
                    end else if (prbs_start) begin
                        state_d = ST_PRBS;
                        tmr_d   = '0;
                    end
                end
                ST_PRBS: begin
                    if (!rx_block_lock) begin
                        state_d    = ST_WAIT_LOCK;
                        tmr_d      = '0;
                        test_end   = 1'b1;
                        test_abort = 1'b1;
                    end else if (tmr_q == PRBS_LAST) begin
                        state_d  = ST_WAIT_LOCK;
                        tmr_d    = '0;
                        test_end = 1'b1;
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_IDLE;
                    tmr_d   = '0;
                end
            endcase
        end
    end

    // Outputs decode the next state so they line up with link_state.
    always_comb begin
        req_d  = (state_d == ST_RESET);
        up_d   = (state_d == ST_LINK_UP);
        fail_d = (state_d == ST_FAIL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tmr_q   <= '0;
            retry_q <= '0;
            down_q  <= '0;
            req_q   <= 1'b0;
            up_q    <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            retry_q <= retry_d;
            down_q  <= down_d;
            req_q   <= req_d;
            up_q    <= up_d;
            fail_q  <= fail_d;
        end
    end

    assign serdes_rx_reset_req = req_q;
    assign link_up             = up_q;
    assign link_fail           = fail_q;
    assign link_state          = state_q;
    assign retry_count         = retry_q;
    assign link_down_count     = down_q;

`ifdef ETH_PHY_10G_LINK_CTRL_PRBS_EN
    localparam int SUM_W = ERR_WIDTH + 8;
    localparam logic [SUM_W-1:0] ACC_MAX = SUM_W'({ERR_WIDTH{1'b1}});

    logic [ERR_WIDTH-1:0] acc_q, acc_d;
    logic [ERR_WIDTH-1:0] errs_q, errs_d;
    logic                 done_q, done_d;
    logic                 abort_q, abort_d;
    logic                 act_q, act_d;
    logic [SUM_W-1:0]     acc_sum;

    always_comb begin
        acc_d   = acc_q;
        errs_d  = errs_q;
        acc_sum = SUM_W'(acc_q) + SUM_W'(rx_error_count);
        if ((state_q == ST_LINK_UP) && (state_d == ST_PRBS)) begin
            acc_d = '0;
        end else if (enable && (state_q == ST_PRBS) && rx_block_lock &&
                     (tmr_q >= TMR_W'(PRBS_SETTLE_CYCLES))) begin
            acc_d = (acc_sum > ACC_MAX) ? {ERR_WIDTH{1'b1}} : acc_sum[ERR_WIDTH-1:0];
        end
        // A disable-abort keeps the previous result; lock loss reports the partial sum.
        if (enable && test_end) begin
            errs_d = acc_d;
        end
        done_d  = test_end;
        abort_d = test_abort;
        act_d   = (state_d == ST_PRBS);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            errs_q  <= '0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            act_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            errs_q  <= errs_d;
            done_q  <= done_d;
            abort_q <= abort_d;
            act_q   <= act_d;
        end
    end

    assign cfg_rx_prbs31_enable = act_q;
    assign cfg_tx_prbs31_enable = act_q;
    assign test_busy            = act_q;
    assign test_done            = done_q;
    assign test_aborted         = abort_q;
    assign test_errors          = errs_q;
`else
    logic unused_prbs;
    assign unused_prbs = ^{test_start, rx_error_count, test_end, test_abort};

    assign cfg_rx_prbs31_enable = 1'b0;
    assign cfg_tx_prbs31_enable = 1'b0;
    assign test_busy            = 1'b0;
    assign test_done            = 1'b0;
    assign test_aborted         = 1'b0;
    assign test_errors          = '0;
`endif

endmodule

// File: tb/tb_eth_phy_10g_link_ctrl.sv
// Bench for eth_phy_10g_link_ctrl: phase/elapsed-time model checked every cycle plus directed literals.
// Inputs driven on the falling edge, outputs compared on the falling edge.
module tb_eth_phy_10g_link_ctrl;

    localparam int RST_C  = 4;
    localparam int LOCK_T = 10;
    localparam int STAB_C = 8;
    localparam int MAXR   = 3;
    localparam int TEST_C = 16;
    localparam int SETL_C = 4;
    localparam int ERR_W  = 6;
    localparam int EMAX   = (1 << ERR_W) - 1;
`ifdef ETH_PHY_10G_LINK_CTRL_PRBS_EN
    localparam bit PRBS_EN = 1'b1;
`else
    localparam bit PRBS_EN = 1'b0;
`endif

    localparam int P_IDLE = 0, P_RST = 1, P_WL = 2, P_WS = 3, P_UP = 4, P_PRBS = 5, P_FAIL = 6;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             enable = 1'b0;
    logic             rx_block_lock = 1'b0;
    logic             rx_high_ber = 1'b0;
    logic [6:0]       rx_error_count = '0;
    logic             test_start = 1'b0;
    logic             serdes_rx_reset_req, link_up, link_fail;
    logic [2:0]       link_state;
    logic [3:0]       retry_count;
    logic [15:0]      link_down_count;
    logic             cfg_rx_prbs31_enable, cfg_tx_prbs31_enable;
    logic             test_busy, test_done, test_aborted;
    logic [ERR_W-1:0] test_errors;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_on  = 1'b0;

    eth_phy_10g_link_ctrl #(
        .RESET_CYCLES(RST_C), .LOCK_TIMEOUT(LOCK_T), .STABLE_CYCLES(STAB_C),
        .MAX_RETRIES(MAXR), .PRBS_TEST_CYCLES(TEST_C), .PRBS_SETTLE_CYCLES(SETL_C),
        .ERR_WIDTH(ERR_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .rx_block_lock(rx_block_lock),
        .rx_high_ber(rx_high_ber), .rx_error_count(rx_error_count), .test_start(test_start),
        .serdes_rx_reset_req(serdes_rx_reset_req), .link_up(link_up), .link_fail(link_fail),
        .link_state(link_state), .retry_count(retry_count), .link_down_count(link_down_count),
        .cfg_rx_prbs31_enable(cfg_rx_prbs31_enable), .cfg_tx_prbs31_enable(cfg_tx_prbs31_enable),
        .test_busy(test_busy), .test_done(test_done), .test_aborted(test_aborted),
        .test_errors(test_errors)
    );

    always #5 clk = ~clk;

    // Model: which phase we are in and how long we've been there.
    int m_ph = 0, m_t = 0, m_retries = 0, m_downs = 0, m_acc = 0, m_errs = 0;
    bit m_done = 1'b0, m_ab = 1'b0;

    always @(posedge clk or negedge rst_n) begin : model
        int ph, t, r, d, acc, errs;
        bit dn, ab, good;
        if (!rst_n) begin
            m_ph <= P_IDLE; m_t <= 0; m_retries <= 0; m_downs <= 0;
            m_acc <= 0; m_errs <= 0; m_done <= 1'b0; m_ab <= 1'b0;
        end else begin
            ph = m_ph; t = m_t; r = m_retries; d = m_downs; acc = m_acc; errs = m_errs;
            dn = 1'b0; ab = 1'b0;
            good = rx_block_lock && !rx_high_ber;
            if (!enable) begin
                if (ph == P_PRBS) begin dn = 1'b1; ab = 1'b1; end
                ph = P_IDLE; t = 0; r = 0;
            end else begin
                case (ph)
                    P_IDLE: begin ph = P_RST; t = 0; end
                    P_RST: begin
                        t++;
                        if (t == RST_C) begin ph = P_WL; t = 0; end
                    end
                    P_WL: begin
                        if (good) begin ph = P_WS; t = 0; end
                        else begin
                            t++;
                            if (t == LOCK_T) begin
                                r = (r < 15) ? r + 1 : 15;
                                ph = (MAXR != 0 && r == MAXR) ? P_FAIL : P_RST;
                                t = 0;
                            end
                        end
                    end
                    P_WS: begin
                        if (!good) begin ph = P_WL; t = 0; end
                        else begin
                            t++;
                            if (t == STAB_C) begin ph = P_UP; t = 0; r = 0; end
                        end
                    end
                    P_UP: begin
                        if (!good) begin ph = P_WL; t = 0; d = (d < 65535) ? d + 1 : 65535; end
                        else if (PRBS_EN && test_start) begin ph = P_PRBS; t = 0; acc = 0; end
                    end
                    P_PRBS: begin
                        if (!rx_block_lock) begin
                            errs = acc; dn = 1'b1; ab = 1'b1; ph = P_WL; t = 0;
                        end else begin
                            if (t >= SETL_C) acc = (acc + rx_error_count > EMAX) ? EMAX : acc + rx_error_count;
                            t++;
                            if (t == SETL_C + TEST_C) begin errs = acc; dn = 1'b1; ph = P_WL; t = 0; end
                        end
                    end
                    default: ;
                endcase
            end
            m_ph <= ph; m_t <= t; m_retries <= r; m_downs <= d;
            m_acc <= acc; m_errs <= errs; m_done <= dn; m_ab <= ab;
        end
    end

    logic [36:0] dut_v, exp_v;
    assign dut_v = {serdes_rx_reset_req, link_up, link_fail, link_state, retry_count, link_down_count,
                    cfg_rx_prbs31_enable, cfg_tx_prbs31_enable, test_busy, test_done, test_aborted,
                    test_errors};
    assign exp_v = {m_ph == P_RST, m_ph == P_UP, m_ph == P_FAIL, 3'(m_ph), 4'(m_retries), 16'(m_downs),
                    m_ph == P_PRBS, m_ph == P_PRBS, m_ph == P_PRBS, m_done, m_ab, ERR_W'(m_errs)};

    always @(negedge clk) begin
        if (cmp_on) begin
            n_tests++;
            if (dut_v !== exp_v) begin
                n_fail++;
                $display("FAIL cycle_cmp t=%0t dut=%h model=%h", $time, dut_v, exp_v);
            end
        end
    end

    task automatic chk(input string name, input logic [36:0] act, input logic [36:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_up(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (link_up) break;
            tick(1);
        end
        chk("wait_link_up", 37'(link_up), 37'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, req_cnt, ws_first, up_cyc, ws_cnt, cfg_cnt, busy_cnt, done_cnt, pulses;
        bit ab_seen, prev_req;
        logic [11:0] rseq;
        logic [3:0]  prev_r;

        #1 rst_n = 1'b0;
        tick(3);
        chk("reset_outputs", dut_v, 37'd0);
        cmp_on = 1'b1;
        rst_n = 1'b1;
        tick(2);

        // Bring-up with lock held good.
        rx_block_lock = 1'b1; enable = 1'b1;
        cyc = 0; req_cnt = 0; ws_first = 0; up_cyc = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1); cyc++;
            if (serdes_rx_reset_req) req_cnt++;
            if (link_state == 3'd3 && ws_first == 0) ws_first = cyc;
            if (link_up) begin up_cyc = cyc; break; end
        end
        chk("reset_req_cycles", 37'(req_cnt), 37'd4);
        chk("link_up_cycle", 37'(up_cyc), 37'd14);
        chk("stable_window", 37'(up_cyc - ws_first), 37'd8);
        chk("state_link_up", 37'(link_state), 37'd4);

        // One-cycle lock drop in LINK_UP, then a glitch inside WAIT_STABLE.
        rx_block_lock = 1'b0; tick(1);
        chk("drop_link_up", 37'(link_up), 37'd0);
        chk("drop_down_count", 37'(link_down_count), 37'd1);
        chk("drop_state", 37'(link_state), 37'd2);
        rx_block_lock = 1'b1; tick(3);
        rx_block_lock = 1'b0; tick(1);
        rx_block_lock = 1'b1;
        ws_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (link_up) break;
            if (link_state == 3'd3) ws_cnt++;
        end
        chk("glitch_restart_ws", 37'(ws_cnt), 37'd8);

`ifdef ETH_PHY_10G_LINK_CTRL_PRBS_EN
        // Full PRBS window, 3 errors per cycle.
        rx_error_count = 7'd3;
        test_start = 1'b1; tick(1); test_start = 1'b0;
        cfg_cnt = 0; busy_cnt = 0; done_cnt = 0; ab_seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (cfg_rx_prbs31_enable && cfg_tx_prbs31_enable) cfg_cnt++;
            if (test_busy) busy_cnt++;
            if (test_done) begin done_cnt++; ab_seen = ab_seen | test_aborted; end
            tick(1);
        end
        chk("prbs_cfg_cycles", 37'(cfg_cnt), 37'd20);
        chk("prbs_busy_cycles", 37'(busy_cnt), 37'd20);
        chk("prbs_done_pulses", 37'(done_cnt), 37'd1);
        chk("prbs_not_aborted", 37'(ab_seen), 37'd0);
        chk("prbs_errors", 37'(test_errors), 37'd48);

        // Lock lost at window cycle 5.
        wait_up(40);
        test_start = 1'b1; tick(1); test_start = 1'b0; tick(9);
        rx_block_lock = 1'b0; tick(1);
        chk("abort_done", 37'(test_done), 37'd1);
        chk("abort_flag", 37'(test_aborted), 37'd1);
        chk("abort_errors", 37'(test_errors), 37'd15);
        rx_block_lock = 1'b1;

        // 7 errors per cycle saturates the 6-bit total.
        rx_error_count = 7'd7;
        wait_up(40);
        test_start = 1'b1; tick(1); test_start = 1'b0; tick(20);
        chk("sat_done", 37'(test_done), 37'd1);
        chk("sat_errors", 37'(test_errors), 37'd63);
        rx_error_count = 7'd0;
`else
        rx_error_count = 7'd5;
        test_start = 1'b1; tick(1); test_start = 1'b0; tick(3);
        chk("nomacro_state", 37'(link_state), 37'd4);
        chk("nomacro_cfg", 37'(cfg_rx_prbs31_enable), 37'd0);
        rx_error_count = 7'd0;
`endif

        // test_start coincident with lock loss.
        wait_up(40);
        test_start = 1'b1; rx_block_lock = 1'b0; tick(1);
        test_start = 1'b0; rx_block_lock = 1'b1;
        chk("tie_state", 37'(link_state), 37'd2);
        chk("tie_busy", 37'(test_busy), 37'd0);

`ifdef ETH_PHY_10G_LINK_CTRL_PRBS_EN
        // Disable during a test.
        wait_up(40);
        test_start = 1'b1; tick(1); test_start = 1'b0; tick(3);
        enable = 1'b0; tick(1);
        chk("dis_done", 37'(test_done), 37'd1);
        chk("dis_aborted", 37'(test_aborted), 37'd1);
        chk("dis_errors_kept", 37'(test_errors), 37'd63);
        chk("dis_state", 37'(link_state), 37'd0);
`else
        enable = 1'b0; tick(1);
`endif

        // No lock at all: retry budget runs out.
        rx_block_lock = 1'b0; enable = 1'b1;
        pulses = 0; prev_req = 1'b0; rseq = '0; prev_r = 4'd0;
        for (int i = 0; i < 80; i++) begin
            tick(1);
            if (serdes_rx_reset_req && !prev_req) pulses++;
            prev_req = serdes_rx_reset_req;
            if (retry_count != prev_r) rseq = {rseq[7:0], retry_count};
            prev_r = retry_count;
        end
        chk("retry_pulses", 37'(pulses), 37'd3);
        chk("retry_sequence", 37'(rseq), 37'h123);
        chk("fail_flag", 37'(link_fail), 37'd1);
        chk("fail_state", 37'(link_state), 37'd6);
        enable = 1'b0; tick(1);
        chk("idle_flags", 37'({link_fail, link_up, serdes_rx_reset_req, retry_count, link_state}), 37'd0);
        chk("downs_kept", 37'(link_down_count), 37'd2);

        // Asynchronous reset mid-operation.
        rx_block_lock = 1'b1; enable = 1'b1; tick(12);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", dut_v, 37'd0);
        @(negedge clk);
        rst_n = 1'b1;
        enable = 1'b0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/eth_phy_10g_link_ctrl.md
Name: eth_phy_10g_link_ctrl

Overview:
- Link bring-up and supervision controller for the 10G PHY receive path, clocked in the RX clock domain.
- Pulses the SERDES RX reset and waits for block lock, then qualifies the link over a stability window.
- Declares link up, re-acquires on loss of lock or high BER, and gives up after a retry budget.
- Optionally sequences a timed PRBS31 loopback test and accumulates the PHY's per-cycle error count.

Parameters:
RESET_CYCLES, 64, cycles serdes_rx_reset_req held high per reset attempt (>=1)
LOCK_TIMEOUT, 1000000, cycles allowed in WAIT_LOCK before a retry (>=1)
STABLE_CYCLES, 19531, consecutive good cycles needed to declare link up (~125 us at 156.25 MHz)
MAX_RETRIES, 15, lock timeouts before FAIL; 0 = unlimited; max 15
PRBS_TEST_CYCLES, 156250, PRBS measurement window in cycles
PRBS_SETTLE_CYCLES, 64, cycles after PRBS enable during which errors are ignored
ERR_WIDTH, 32, width of PRBS error accumulator

Ports:
clk  in  1  clock (PHY RX clock)
rst_n  in  1  asynchronous active-low reset
enable  in  1  level; 1 = run link bring-up, 0 = idle
rx_block_lock  in  1  block lock from PHY RX
rx_high_ber  in  1  high-BER flag from PHY RX
rx_error_count  in  7  PRBS error bits this cycle from PHY RX
test_start  in  1  single-cycle PRBS test request
serdes_rx_reset_req  out  1  SERDES RX reset request
link_up  out  1  link qualified
link_fail  out  1  retry budget exhausted
link_state  out  3  current FSM state encoding
retry_count  out  4  lock timeouts since last link up
link_down_count  out  16  LINK_UP exits, saturating
cfg_rx_prbs31_enable  out  1  to PHY RX
cfg_tx_prbs31_enable  out  1  to PHY TX; quasi-static, integrator synchronises
test_busy  out  1  PRBS test in progress
test_done  out  1  one-cycle pulse at test end
test_aborted  out  1  valid with test_done; 1 = lock lost mid-test
test_errors  out  ERR_WIDTH  latched error total, saturating

Behaviour:
- Reset: every output is 0. State is IDLE and all counters are cleared.
- All outputs are registered.
- State encoding: IDLE=0, RESET=1, WAIT_LOCK=2, WAIT_STABLE=3, LINK_UP=4, PRBS=5, FAIL=6.
- enable=0 in any state has top priority: next state is IDLE.
  - Clears serdes_rx_reset_req, link_up, link_fail, retry_count, the PRBS cfg outputs and test_busy.
  - link_down_count and test_errors are kept.
  - If a test is in flight: test_done=1 and test_aborted=1 for one cycle.
- IDLE: enable=1 -> RESET.
- RESET: serdes_rx_reset_req=1 for exactly RESET_CYCLES cycles, then -> WAIT_LOCK with serdes_rx_reset_req=0.
- WAIT_LOCK: timer starts at 0.
  - rx_block_lock=1 and rx_high_ber=0 -> WAIT_STABLE.
  - Otherwise, when the timer reaches LOCK_TIMEOUT-1, retry_count increments.
  - If MAX_RETRIES!=0 and the new retry_count==MAX_RETRIES -> FAIL; else -> RESET.
  - Lock wins over timeout in the same cycle.
- WAIT_STABLE: counts consecutive cycles with lock=1 and high_ber=0.
  - Any bad cycle -> WAIT_LOCK with the timer restarted.
  - Count reaching STABLE_CYCLES -> LINK_UP with retry_count cleared.
- LINK_UP: link_up=1.
  - lock=0 or high_ber=1 -> WAIT_LOCK, link_up=0 next cycle, link_down_count +1 (saturates at 0xFFFF).
  - Otherwise test_start=1 -> PRBS.
  - Lock loss together with test_start: lock loss wins and the test is ignored.
- test_start outside LINK_UP is ignored.
- PRBS: cfg_rx/tx_prbs31_enable=1 and test_busy=1; the accumulator clears on entry.
  - First PRBS_SETTLE_CYCLES cycles: rx_error_count is ignored.
  - Next PRBS_TEST_CYCLES cycles: the accumulator adds rx_error_count, saturating at all-ones.
  - Window end: test_errors <= accumulator, test_done=1, test_aborted=0, cfg outputs drop, -> WAIT_LOCK to re-qualify.
  - rx_block_lock=0 at any time: test_errors <= accumulator so far, test_done=1, test_aborted=1, -> WAIT_LOCK.
  - rx_high_ber is ignored while in PRBS.
- FAIL: link_fail=1 and serdes_rx_reset_req=0. Held until enable=0.
- Asynchronous reset mid-operation returns to the reset values immediately.

Optional Feature:
- Macro: ETH_PHY_10G_LINK_CTRL_PRBS_EN.
- Defined: PRBS state, test ports and cfg outputs function as described.
- Undefined:
  - test_start is ignored and the PRBS state is unreachable.
  - cfg_rx/tx_prbs31_enable, test_busy, test_done, test_aborted and test_errors are tied to 0.
  - No accumulator logic is synthesised.

Test Plan:
- Reset, then enable=1 with lock=1 constant, RESET_CYCLES=4, STABLE_CYCLES=8 -> serdes_rx_reset_req high exactly 4 cycles; link_up rises 8 good cycles after WAIT_STABLE entry; link_state=4.
- Lock held 0, LOCK_TIMEOUT=10, MAX_RETRIES=3 -> three reset pulses, retry_count 1,2,3, then link_fail=1, link_state=6; enable=0 -> IDLE with all flags clear.
- In LINK_UP, drop lock 1 cycle -> link_up=0, link_down_count=1, state WAIT_LOCK; lock glitch in WAIT_STABLE restarts the stable count (link_up delayed by a full STABLE_CYCLES).
- PRBS_EN defined, SETTLE=4, TEST=16, rx_error_count=3 every cycle -> test_errors=48, test_done one-cycle pulse, test_aborted=0, cfg outputs high exactly 20 cycles.
- Same test with lock dropped at window cycle 5 -> test_done with test_aborted=1, test_errors=15; ERR_WIDTH=4 with errors=7/cycle -> test_errors saturates at 15.
- test_start in the same cycle as lock loss in LINK_UP -> no PRBS entry, state WAIT_LOCK; macro undefined -> test_start never changes state.
